// File: rtl/paralelo_serial_tx.sv
// Serial transmit end of the link. After reset it sends N_TRAIN COM symbols
// so the receiver can align. After that it sends accepted bytes, or IDLE when
// no byte is offered. Symbols are serialised MSB first, one bit per clock.
//
// Handshake: ready_out is high for the single cycle before each symbol load
// edge once training is over. A byte is transferred on a rising edge where
// ready_out && valid_in. The producer keeps data_in/valid_in stable until
// that edge. valid_in while ready_out is low is ignored.
module paralelo_serial_tx #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter logic [7:0] IDLE    = 8'h7C,
  parameter int         N_TRAIN = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       symbol_strobe,
  output logic       active_out,
  output logic       state_dbg_o
);

  // Wide enough to hold N_TRAIN. The counter only advances in TRAIN, so it
  // stops changing once the link is active.
  localparam int TW = $clog2(N_TRAIN + 1);

  typedef enum logic [0:0] {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  train_cnt_q, train_cnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           data_out_q, data_out_d;
  logic           strobe_q, strobe_d;
  logic           active_q, active_d;

  logic           load;
  logic           last_train;
  logic [7:0]     next_sym;

  // A new symbol is taken in whenever the bit counter is about to leave 0.
  assign load       = (bit_cnt_q == 3'd0);
  assign last_train = (train_cnt_q == TW'(N_TRAIN - 1));

  // State register.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= TRAIN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave TRAIN on the load edge of the last COM. ACTIVE is final.
  always_comb begin
    state_d = state_q;
    if ((state_q == TRAIN) && load && last_train) begin
      state_d = ACTIVE;
    end
  end

  // FSM outputs: ready and symbol select decoded from registers and inputs.
  always_comb begin
    ready_out   = (state_q == ACTIVE) && load;
    state_dbg_o = state_q;
    next_sym    = COM;
    if (state_q == ACTIVE) begin
      next_sym = valid_in ? data_in : IDLE;
    end
  end

  // Datapath next-state: bit counter, training counter, hold and serial bit.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    train_cnt_d = train_cnt_q;
    hold_d      = hold_q;
    data_out_d  = hold_q[3'd7 - bit_cnt_q];
    strobe_d    = 1'b0;
    active_d    = active_q;
    if (load) begin
      hold_d     = next_sym;
      data_out_d = next_sym[7];
      strobe_d   = 1'b1;
      if (state_q == TRAIN) begin
        train_cnt_d = train_cnt_q + TW'(1);
      end else begin
        active_d = 1'b1;
      end
    end
  end

  // Datapath registers. An asynchronous reset aborts any symbol in flight.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= 3'd0;
      train_cnt_q <= '0;
      hold_q      <= 8'h00;
      data_out_q  <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      train_cnt_q <= train_cnt_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign data_out      = data_out_q;
  assign symbol_strobe = strobe_q;
  assign active_out    = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx. The driver pushes each expected symbol into
// exp_q as it issues it. The monitor rebuilds symbols from the serial stream
// and pops and compares them.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk_4f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       symbol_strobe;
  logic       active_out;
  logic       state_dbg;

  int checks = 0;
  int passes = 0;
  int edge_n;

  logic [7:0] exp_q[$];
  logic [7:0] mon_sym;
  int         mon_idx;

  paralelo_serial_tx #(.COM(COM), .IDLE(IDLE), .N_TRAIN(4)) dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .symbol_strobe (symbol_strobe),
    .active_out    (active_out),
    .state_dbg_o   (state_dbg)
  );

  // Clock and reset.
  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  // Edge 1 is the first rising edge after reset release.
  always @(posedge clk_4f or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  // Monitor: rebuilds symbols on the falling edge and checks strobe placement.
  always @(negedge clk_4f) begin
    if (!reset) begin
      mon_idx = 0;
    end else if (edge_n > 0) begin
      check("strobe_pos", {7'd0, symbol_strobe}, {7'd0, (mon_idx == 0)});
      if (symbol_strobe) mon_idx = 0;
      mon_sym = {mon_sym[6:0], data_out};
      mon_idx++;
      if (mon_idx == 8) begin
        mon_idx = 0;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_symbol got=%h exp=none t=%0t", mon_sym, $time);
        end else begin
          check("symbol", mon_sym, exp_q.pop_front());
        end
      end
    end
  end

  // Drive reset low shortly after a falling edge. Check outputs clear with no clock.
  task automatic do_reset();
    @(negedge clk_4f);
    #2;
    reset    = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    #1;
    check("rst_data_out", {7'd0, data_out}, 8'd0);
    check("rst_strobe",   {7'd0, symbol_strobe}, 8'd0);
    check("rst_active",   {7'd0, active_out}, 8'd0);
    check("rst_ready",    {7'd0, ready_out}, 8'd0);
    repeat (3) @(negedge clk_4f);
    reset = 1'b1;
  endtask

  // Training window: 4 COMs, edges 1..32. Optionally raise valid before edge 5.
  task automatic train_phase(input logic early_v, input logic [7:0] early_d);
    repeat (4) exp_q.push_back(COM);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_4f);
      if (k == 4 && early_v) begin
        valid_in = 1'b1;
        data_in  = early_d;
      end
      if (k == 1) begin
        check("train_active0", {7'd0, active_out}, 8'd0);
        check("train_state",   {7'd0, state_dbg}, 8'd0);
      end
      if (k == 5 || k == 9 || k == 17 || k == 25 || k == 31)
        check("train_ready0", {7'd0, ready_out}, 8'd0);
      if (k == 25) check("train_active_e25", {7'd0, active_out}, 8'd0);
      if (k == 32) check("state_active", {7'd0, state_dbg}, 8'd1);
    end
  endtask

  // One 8-clock slot. It starts at the falling edge just before a load edge.
  task automatic slot(input logic v, input logic [7:0] d);
    logic [7:0] e;
    e = v ? d : IDLE;
    check("ready_at_load", {7'd0, ready_out}, 8'd1);
    valid_in = v;
    data_in  = d;
    exp_q.push_back(e);
    @(negedge clk_4f);
    check("strobe_after_load", {7'd0, symbol_strobe}, 8'd1);
    check("msb_latency",       {7'd0, data_out}, {7'd0, e[7]});
    check("ready_mid",         {7'd0, ready_out}, 8'd0);
    check("active_on",         {7'd0, active_out}, 8'd1);
    data_in = ~d;
    repeat (7) @(negedge clk_4f);
    valid_in = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    mon_idx  = 0;
    mon_sym  = 8'h00;
    do_reset();

    // Training, one IDLE, back-to-back bytes, a gap, then COM/IDLE as data.
    train_phase(1'b0, 8'h00);
    slot(1'b0, 8'h00);
    slot(1'b1, 8'hFF);
    slot(1'b1, 8'hEE);
    slot(1'b1, 8'hDD);
    slot(1'b1, 8'hCC);
    slot(1'b1, 8'hBB);
    slot(1'b0, 8'h00);
    slot(1'b1, 8'hAA);
    slot(1'b1, 8'hBC);
    slot(1'b1, 8'h7C);
    slot(1'b0, 8'h00);
    @(negedge clk_4f);
    check("drained_a", 8'(exp_q.size()), 8'd0);

    // Valid raised during training, then reset mid-symbol after edge 44.
    do_reset();
    train_phase(1'b1, 8'h77);
    slot(1'b1, 8'h77);
    check("ready_at_load", {7'd0, ready_out}, 8'd1);
    valid_in = 1'b1;
    data_in  = 8'h5A;
    repeat (4) @(negedge clk_4f);
    check("pre_reset_bit", {7'd0, data_out}, 8'd1);
    check("drained_b", 8'(exp_q.size()), 8'd0);
    #2;
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    check("abort_data_out", {7'd0, data_out}, 8'd0);
    check("abort_strobe",   {7'd0, symbol_strobe}, 8'd0);
    check("abort_active",   {7'd0, active_out}, 8'd0);
    check("abort_ready",    {7'd0, ready_out}, 8'd0);
    repeat (3) @(negedge clk_4f);
    reset = 1'b1;

    // Training restarts from the first COM, then IDLE.
    train_phase(1'b0, 8'h00);
    slot(1'b0, 8'h00);
    slot(1'b0, 8'h00);
    @(negedge clk_4f);
    check("drained_c", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
